// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI-to-RAM bridge: FSM states, command codes, select bits.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    EXEC,
    TX
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam logic SEL_WRITE = 1'b0;
  localparam logic SEL_READ  = 1'b1;

endpackage

// File: rtl/spi_mem_array.sv
// Bridge storage: synchronous write, registered one-cycle read, contents not reset.
module spi_mem_array #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/spi_mem_bridge.sv
// SPI slave that executes address/data commands on an internal RAM and returns read data on miso.
// Build option SPI_AUTO_INC_EN: post-increment wr_addr/rd_addr after data accesses (bursts).
module spi_mem_bridge
  import spi_mem_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic ss_n,
  input  logic mosi,
  output logic miso,
  output logic busy,
  output logic err
);

  localparam int unsigned PAY_W = DATA_W + 2;
  localparam int unsigned CNT_W = $clog2(PAY_W);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              miso_n, err_n;
  logic [PAY_W-1:0]  sh;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              rd_addr_seen, sel, rd_src;
  logic              sel_ld, shift_en, ld_wr, inc_wr, ld_rd, ram_we, ram_re;
  logic              tx_load, tx_shift, tx_end;
  logic [1:0]        cmd;

  assign cmd = sh[PAY_W-1 -: 2];

  // Next-state, output and datapath-strobe decode.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    miso_n   = 1'b0;
    err_n    = 1'b0;
    sel_ld   = 1'b0;
    shift_en = 1'b0;
    ld_wr    = 1'b0;
    inc_wr   = 1'b0;
    ld_rd    = 1'b0;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    tx_end   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!ss_n) state_n = CHK_CMD;
      end
      CHK_CMD: begin
        if (ss_n) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else begin
          sel_ld = 1'b1;
          cnt_n  = '0;
          if (mosi == SEL_WRITE)  state_n = WRITE;
          else if (rd_addr_seen)  state_n = READ_DATA;
          else                    state_n = READ_ADD;
        end
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (ss_n) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else begin
          shift_en = 1'b1;
          if (cnt == CNT_W'(PAY_W - 1)) begin
            state_n = EXEC;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      EXEC: begin
        state_n = IDLE;
        if ((cmd[1] != sel) || ((cmd == CMD_RD_DATA) && !rd_src)) begin
          err_n = 1'b1;
        end else begin
          case (cmd)
            CMD_WR_ADDR: ld_wr = 1'b1;
            CMD_WR_DATA: begin
              ram_we = 1'b1;
`ifdef SPI_AUTO_INC_EN
              inc_wr = 1'b1;
`endif
            end
            CMD_RD_ADDR: ld_rd = 1'b1;
            default: begin
              // A read cannot complete once the master has deselected.
              if (ss_n) begin
                err_n = 1'b1;
              end else begin
                ram_re  = 1'b1;
                state_n = TX;
                cnt_n   = '0;
              end
            end
          endcase
        end
      end
      TX: begin
        if (cnt == CNT_W'(DATA_W)) begin
          state_n = IDLE;
          tx_end  = 1'b1;
        end else if (ss_n) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else begin
          // First TX cycle is the RAM latency: take the MSB straight from rdata.
          miso_n   = (cnt == '0) ? rdata[DATA_W-1] : tx_sh[DATA_W-1];
          tx_load  = (cnt == '0);
          tx_shift = (cnt != '0);
          cnt_n    = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      miso  <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      miso  <= miso_n;
      busy  <= (state_n != IDLE);
      err   <= err_n;
    end
  end

  // Shift registers and address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh           <= '0;
      tx_sh        <= '0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      rd_addr_seen <= 1'b0;
      sel          <= 1'b0;
      rd_src       <= 1'b0;
    end else begin
      if (sel_ld) begin
        sel    <= mosi;
        rd_src <= (mosi == SEL_READ) && rd_addr_seen;
      end
      if (shift_en) sh <= {sh[PAY_W-2:0], mosi};
      if (ld_wr)       wr_addr <= sh[ADDR_W-1:0];
      else if (inc_wr) wr_addr <= wr_addr + ADDR_W'(1);
      if (ld_rd) begin
        rd_addr      <= sh[ADDR_W-1:0];
        rd_addr_seen <= 1'b1;
      end
      if (tx_load)       tx_sh <= rdata << 1;
      else if (tx_shift) tx_sh <= tx_sh << 1;
      if (tx_end) begin
`ifdef SPI_AUTO_INC_EN
        rd_addr <= rd_addr + ADDR_W'(1);
`else
        rd_addr_seen <= 1'b0;
`endif
      end
    end
  end

  spi_mem_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wr_addr),
    .wdata(sh[DATA_W-1:0]),
    .re   (ram_re),
    .raddr(rd_addr),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Frame-level bench for spi_mem_bridge (DATA_W=8); expectations follow SPI_AUTO_INC_EN if defined.
module tb_spi_mem_bridge;
  import spi_mem_pkg::*;

  logic clk = 1'b0;
  logic rst, ss_n, mosi;
  logic miso, busy, err;

  always #5 clk = ~clk;

  spi_mem_bridge #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .ss_n(ss_n),
    .mosi(mosi),
    .miso(miso),
    .busy(busy),
    .err (err)
  );

  typedef struct {
    logic       sel;
    logic [1:0] cmd;
    logic [7:0] data;
    int         cut;      // payload bits sent before ss_n rises; 0 = full frame
    int         exp_err;  // expected number of err pulses
    bit         rd_ok;    // frame returns read data
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl [33];
  vec_t exp_q [$];
  int   total = 0;
  int   bad = 0;
  int   err_cnt = 0;
  int   vidx = 0;

  always @(negedge clk) if (err === 1'b1) err_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic vec_t mk(logic s, logic [1:0] c, logic [7:0] d, int cut, int e,
                              bit r, logic [7:0] x);
    vec_t v;
    v.sel = s; v.cmd = c; v.data = d; v.cut = cut; v.exp_err = e; v.rd_ok = r; v.exp_rd = x;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (vec %0d): got %0h required %0h", nm, vidx, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v);
    vec_t       e;
    logic [9:0] pay;
    logic [7:0] got;
    int         e0;
    bit         cut_hit;
    logic       miso_hi;
    exp_q.push_back(v);
    e0 = err_cnt; pay = {v.cmd, v.data}; got = '0; cut_hit = 1'b0; miso_hi = 1'b0;
    @(negedge clk); ss_n = 1'b0; mosi = 1'b0;
    @(negedge clk); mosi = v.sel;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      miso_hi |= miso;
      if (i == 2) chk("busy_mid", 32'(busy), 32'd1);
      if (v.cut != 0 && i == v.cut) begin
        cut_hit = 1'b1;
        break;
      end
      mosi = pay[9-i];
    end
    if (!cut_hit) begin
      @(negedge clk); mosi = 1'b0; miso_hi |= miso;
      if (v.rd_ok) begin
        @(negedge clk); miso_hi |= miso;
        for (int b = 7; b >= 0; b--) begin
          @(negedge clk);
          got[b] = miso;
        end
      end else begin
        @(negedge clk);
      end
    end
    ss_n = 1'b1; mosi = 1'b0;
    repeat (3) begin
      @(negedge clk);
      miso_hi |= miso;
    end
    e = exp_q.pop_front();
    chk("err_pulses", 32'(err_cnt - e0), 32'(e.exp_err));
    chk("busy_end", 32'(busy), 32'd0);
    chk("miso_quiet", 32'(miso_hi), 32'd0);
    if (e.rd_ok) chk("rd_data", 32'(got), 32'(e.exp_rd));
  endtask

  initial begin
    logic [9:0] pay;
    tbl[0]  = mk(1, CMD_RD_DATA, 8'h00, 0, 1, 0, 8'h00);
    tbl[1]  = mk(0, CMD_WR_ADDR, 8'h0F, 0, 0, 0, 8'h00);
    tbl[2]  = mk(0, CMD_WR_DATA, 8'hA5, 0, 0, 0, 8'h00);
    tbl[3]  = mk(0, CMD_WR_ADDR, 8'h10, 0, 0, 0, 8'h00);
    tbl[4]  = mk(0, CMD_WR_DATA, 8'h5A, 0, 0, 0, 8'h00);
    tbl[5]  = mk(1, CMD_RD_ADDR, 8'h0F, 0, 0, 0, 8'h00);
    tbl[6]  = mk(1, CMD_RD_DATA, 8'h00, 0, 0, 1, 8'hA5);
`ifdef SPI_AUTO_INC_EN
    tbl[7]  = mk(1, CMD_RD_DATA, 8'h00, 0, 0, 1, 8'h5A);
`else
    tbl[7]  = mk(1, CMD_RD_DATA, 8'h00, 0, 1, 0, 8'h00);
`endif
    tbl[8]  = mk(1, CMD_RD_ADDR, 8'h10, 0, 0, 0, 8'h00);
    tbl[9]  = mk(0, CMD_RD_ADDR, 8'h0F, 0, 1, 0, 8'h00);
    tbl[10] = mk(1, CMD_RD_DATA, 8'h00, 0, 0, 1, 8'h5A);
    tbl[11] = mk(1, CMD_WR_DATA, 8'h99, 0, 1, 0, 8'h00);
    tbl[12] = mk(1, CMD_RD_ADDR, 8'h10, 0, 0, 0, 8'h00);
    tbl[13] = mk(1, CMD_RD_DATA, 8'h00, 0, 0, 1, 8'h5A);
    tbl[14] = mk(0, CMD_WR_ADDR, 8'h20, 0, 0, 0, 8'h00);
    tbl[15] = mk(0, CMD_WR_DATA, 8'hC3, 0, 0, 0, 8'h00);
    tbl[16] = mk(0, CMD_WR_ADDR, 8'h20, 0, 0, 0, 8'h00);
    tbl[17] = mk(0, CMD_WR_DATA, 8'h3C, 5, 1, 0, 8'h00);
    tbl[18] = mk(1, CMD_RD_ADDR, 8'h20, 0, 0, 0, 8'h00);
    tbl[19] = mk(1, CMD_RD_DATA, 8'h00, 0, 0, 1, 8'hC3);
    tbl[20] = mk(0, CMD_WR_DATA, 8'h3C, 0, 0, 0, 8'h00);
    tbl[21] = mk(1, CMD_RD_ADDR, 8'h20, 0, 0, 0, 8'h00);
    tbl[22] = mk(1, CMD_RD_DATA, 8'h00, 0, 0, 1, 8'h3C);
    tbl[23] = mk(0, CMD_WR_ADDR, 8'h00, 0, 0, 0, 8'h00);
    tbl[24] = mk(0, CMD_WR_DATA, 8'h77, 0, 0, 0, 8'h00);
    tbl[25] = mk(0, CMD_WR_ADDR, 8'hFF, 0, 0, 0, 8'h00);
    tbl[26] = mk(0, CMD_WR_DATA, 8'h11, 0, 0, 0, 8'h00);
    tbl[27] = mk(0, CMD_WR_DATA, 8'h22, 0, 0, 0, 8'h00);
    tbl[28] = mk(1, CMD_RD_ADDR, 8'hFF, 0, 0, 0, 8'h00);
    tbl[31] = mk(1, CMD_RD_ADDR, 8'h00, 0, 0, 0, 8'h00);
`ifdef SPI_AUTO_INC_EN
    tbl[29] = mk(1, CMD_RD_DATA, 8'h00, 0, 0, 1, 8'h11);
    tbl[30] = mk(1, CMD_RD_DATA, 8'h00, 0, 0, 1, 8'h22);
    tbl[32] = mk(1, CMD_RD_DATA, 8'h00, 0, 0, 1, 8'h22);
`else
    tbl[29] = mk(1, CMD_RD_DATA, 8'h00, 0, 0, 1, 8'h22);
    tbl[30] = mk(1, CMD_RD_DATA, 8'h00, 0, 1, 0, 8'h00);
    tbl[32] = mk(1, CMD_RD_DATA, 8'h00, 0, 0, 1, 8'h77);
`endif

    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_miso", 32'(miso), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 33; i++) begin
      vidx = i;
      run_frame(tbl[i]);
    end

    // Reset in the middle of a read transfer.
    vidx = 100;
    run_frame(mk(1, CMD_RD_ADDR, 8'h0F, 0, 0, 0, 8'h00));
    pay = {CMD_RD_DATA, 8'h00};
    @(negedge clk); ss_n = 1'b0; mosi = 1'b0;
    @(negedge clk); mosi = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mosi = pay[9-i];
    end
    @(negedge clk); mosi = 1'b0;
    @(negedge clk);
    @(negedge clk); chk("tx_bit7", 32'(miso), 32'd1);
    @(negedge clk); chk("tx_bit6", 32'(miso), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ss_n = 1'b1;
    chk("rst_tx_miso", 32'(miso), 32'd0);
    chk("rst_tx_busy", 32'(busy), 32'd0);
    chk("rst_tx_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);

    // Reset clears rd_addr_seen and wr_addr.
    vidx = 101;
    run_frame(mk(1, CMD_RD_DATA, 8'h00, 0, 1, 0, 8'h00));
    vidx = 102;
    run_frame(mk(0, CMD_WR_DATA, 8'h44, 0, 0, 0, 8'h00));
    vidx = 103;
    run_frame(mk(1, CMD_RD_ADDR, 8'h00, 0, 0, 0, 8'h00));
    vidx = 104;
    run_frame(mk(1, CMD_RD_DATA, 8'h00, 0, 0, 1, 8'h44));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
